remote_blink_ctrl: RTL and testbench
====================================

# remote_blink_ctrl

Upstream control stage for the LED blinker: receives 8N1 UART command bytes from a host and holds the blinker's configuration registers. The registers are the LED pattern, the blink-rate divisor and the enable. A two-byte command protocol updates them, and each accepted update is flagged to the blinker with a one-cycle pulse. The block contains a UART receiver front end and a command parser with an argument timeout.

## Interface
- CLK_FREQ, 25_000_000: clock frequency in Hz.
- BAUD, 115_200: UART bit rate. BIT_CYCLES = CLK_FREQ/BAUD, integer division.
- DEFAULT_PATTERN, 8'hFF: reset value of `pattern`.
- DEFAULT_DIV, 8'd4: reset value of `divisor`.
- TIMEOUT_CYCLES, CLK_FREQ/10: maximum idle gap allowed between opcode and argument.
- clk  in  1  system clock. This is the block's only clock.
- rst  in  1  reset, synchronous, active-high.
- uart_rx  in  1  asynchronous serial input. The line idles high.
- pattern  out  8  LED pattern that the blinker toggles.
- divisor  out  8  blink rate. The blinker toggles every CLK_FREQ/divisor cycles. Never 0.
- blink_en  out  1  blinker enable.
- cfg_update  out  1  one-cycle pulse on any accepted command.
- frame_err  out  1  one-cycle pulse on a bad stop bit.

## Operation
- Reset values:
  - pattern = DEFAULT_PATTERN, divisor = DEFAULT_DIV, blink_en = 1.
  - cfg_update = 0, frame_err = 0.
  - Both synchronizer flops = 1.
  - Both state machines return to IDLE.
  - All counters = 0.
- Reset mid-frame or mid-command discards the partial byte or command without exception.
- `uart_rx` passes through a 2-flop synchronizer. All logic uses only the synchronized value `rx_s`.
- RX state machine: RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE -> RX_START on `rx_s` == 0. The bit counter is cleared.
  - RX_START: at count BIT_CYCLES/2 - 1, `rx_s` is sampled.
    - 1 is a false start: go to RX_IDLE, no output.
    - 0: clear the counter and go to RX_DATA.
  - RX_DATA: sample every BIT_CYCLES cycles. 8 bits, LSB first, shifted into the data register. After bit 7, go to RX_STOP.
  - RX_STOP: sample after BIT_CYCLES cycles.
    - 1: pulse `byte_valid` with `byte_data`.
    - 0: pulse `frame_err` and discard the byte.
    - Either way go to RX_IDLE.
  - RX_IDLE only accepts a new start when `rx_s` == 0. A broken stop bit followed by a held-low line therefore re-arms as a new start. This is accepted behaviour.
- Parser state machine: P_IDLE, P_ARG.
  - P_IDLE accepts opcodes 'P' (0x50), 'D' (0x44) and 'E' (0x45). The opcode is latched and the parser goes to P_ARG with the timeout counter cleared. Any other byte is ignored.
  - P_ARG, on `byte_valid`, applies the argument and returns to P_IDLE:
    - 'P': pattern <= arg.
    - 'D': divisor <= arg, but only if arg != 0. Arg 0 is rejected: no register change and no `cfg_update`.
    - 'E': blink_en <= arg[0].
  - P_ARG, when the timeout counter reaches TIMEOUT_CYCLES - 1 without `byte_valid`, returns to P_IDLE silently.
  - `frame_err` in any parser state forces P_IDLE and discards the latched opcode.
- `cfg_update` is asserted only when a register write is accepted. Rewriting the same value still counts and still pulses.

## Timing
- `uart_rx` to `rx_s`: 2 cycles.
- `byte_valid` is asserted for exactly 1 cycle, on the cycle after the stop-bit sample.
- Register write and `cfg_update` are in the same cycle, 1 cycle after `byte_valid`. New output values are visible on the same edge on which `cfg_update` rises.
- `frame_err` is asserted for exactly 1 cycle, on the cycle after the stop-bit sample.
- Back-to-back frames with no idle gap between the stop bit and the next start bit must be received without loss.
- `byte_valid` and the timeout limit in the same cycle: `byte_valid` wins and the argument is applied.
- Counter widths:
  - The bit counter must hold BIT_CYCLES - 1.
  - The timeout counter must hold TIMEOUT_CYCLES - 1.
  - Neither counter may wrap.

## Structure
- Package `remote_blink_pkg` holds:
  - Opcode constants OP_PATTERN, OP_DIV, OP_EN.
  - RX state encodings and parser state encodings.
  - The BIT_CYCLES and half-bit derivation helpers.
- Sub-module `uart_rx_byte` contains the synchronizer and the RX state machine. Its outputs are `byte_valid`, `byte_data[7:0]` and `frame_err`.
- The parser and output registers live in the top module.

## Test plan
- Bench parameters: CLK_FREQ = 1_000_000, BAUD = 100_000 (BIT_CYCLES = 10), TIMEOUT_CYCLES = 200.
- Reset -> pattern = 0xFF, divisor = 4, blink_en = 1. No pulses on any output for 100 cycles.
- Send 0x50 then 0xA5 back-to-back -> pattern = 0xA5. A single `cfg_update` pulse arrives 1 cycle after the second stop-bit sample plus 1. No `frame_err`.
- Send 0x44, 0x00, then 0x44, 0x10 -> the first command has no effect and no pulse. The second gives divisor = 0x10 and one pulse.
- Send 0x45, then wait 250 cycles, then send 0x00 -> the timeout drops the opcode. blink_en stays 1, no pulse.
- Send 0x50 with the stop bit driven low, then 0x33 -> one `frame_err` pulse. The parser is in P_IDLE and 0x33 is ignored as an unknown opcode. pattern is unchanged.
- Send a 3-cycle low glitch on `uart_rx` -> false start rejected, no byte.
- Send 0x50, assert `rst` during the argument byte, then send a full 0x50, 0x0F -> pattern returns to 0xFF on reset, then becomes 0x0F.

Source files
------------

// File: rtl/remote_blink_pkg.sv
// Shared constants and helpers for the remote blink control slice:
// opcodes, FSM encodings and UART timing derivations.
`timescale 1ns/1ps
package remote_blink_pkg;

    localparam logic [7:0] OP_PATTERN = 8'h50;
    localparam logic [7:0] OP_DIV     = 8'h44;
    localparam logic [7:0] OP_EN      = 8'h45;

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [0:0] P_IDLE = 1'b0;
    localparam logic [0:0] P_ARG  = 1'b1;

    function automatic int bit_cycles(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Count value at which the start bit is re-checked mid-bit.
    function automatic int half_bit_last(input int bc);
        return (bc / 2 > 0) ? (bc / 2 - 1) : 0;
    endfunction

    // Width of a counter that must hold max_count - 1.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_PATTERN) || (b == OP_DIV) || (b == OP_EN);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer plus a mid-bit sampling FSM
// that emits one-cycle byte_valid / frame_err pulses.
`timescale 1ns/1ps
module uart_rx_byte
    import remote_blink_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int BIT_CYCLES = bit_cycles(CLK_FREQ, BAUD);
    localparam int CW         = cnt_width(BIT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(half_bit_last(BIT_CYCLES));

    logic [1:0]    sync_q, sync_d;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          rx_s;

    assign rx_s = sync_q[1];

    // Next-state logic: synchronizer shift and start/data/stop sampling.
    always_comb begin
        sync_d  = {sync_q[0], uart_rx};
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    state_d = RX_START;
                    cnt_d   = '0;
                end
            end
            RX_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = RX_IDLE;
                    end else begin
                        state_d = RX_DATA;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d  = '0;
                    data_d = {rx_s, data_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    state_d = RX_IDLE;
                    if (rx_s) begin
                        valid_d = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = RX_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; reset drops any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign byte_valid = valid_q;
    assign byte_data  = data_q;
    assign frame_err  = ferr_q;

endmodule

// File: rtl/remote_blink_ctrl.sv
// Command parser and configuration registers for the LED blinker,
// fed by the UART byte receiver.
`timescale 1ns/1ps
module remote_blink_ctrl
    import remote_blink_pkg::*;
#(
    parameter int         CLK_FREQ        = 25_000_000,
    parameter int         BAUD            = 115_200,
    parameter logic [7:0] DEFAULT_PATTERN = 8'hFF,
    parameter logic [7:0] DEFAULT_DIV     = 8'd4,
    parameter int         TIMEOUT_CYCLES  = CLK_FREQ / 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] pattern,
    output logic [7:0] divisor,
    output logic       blink_en,
    output logic       cfg_update,
    output logic       frame_err
);

    localparam int TW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ferr;

    logic [0:0]    pst_q, pst_d;
    logic [7:0]    op_q, op_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    pattern_q, pattern_d;
    logic [7:0]    divisor_q, divisor_d;
    logic          en_q, en_d;
    logic          upd_q, upd_d;

    uart_rx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .byte_valid (rx_valid),
        .byte_data  (rx_data),
        .frame_err  (rx_ferr)
    );

    // Parser: latch opcode, apply argument, drop it on timeout or frame error.
    always_comb begin
        pst_d     = pst_q;
        op_d      = op_q;
        tmo_d     = tmo_q;
        pattern_d = pattern_q;
        divisor_d = divisor_q;
        en_d      = en_q;
        upd_d     = 1'b0;
        if (rx_ferr) begin
            pst_d = P_IDLE;
        end else begin
            case (pst_q)
                P_IDLE: begin
                    if (rx_valid && is_opcode(rx_data)) begin
                        op_d  = rx_data;
                        pst_d = P_ARG;
                        tmo_d = '0;
                    end
                end
                P_ARG: begin
                    if (rx_valid) begin
                        pst_d = P_IDLE;
                        unique case (1'b1)
                            (op_q == OP_PATTERN): begin
                                pattern_d = rx_data;
                                upd_d     = 1'b1;
                            end
                            (op_q == OP_DIV): begin
                                // Zero would stall the blinker; reject it.
                                if (rx_data != 8'd0) begin
                                    divisor_d = rx_data;
                                    upd_d     = 1'b1;
                                end
                            end
                            (op_q == OP_EN): begin
                                en_d  = rx_data[0];
                                upd_d = 1'b1;
                            end
                            default: begin
                                pst_d = P_IDLE;
                            end
                        endcase
                    end else if (tmo_q == TMO_LAST) begin
                        pst_d = P_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
                default: begin
                    pst_d = P_IDLE;
                end
            endcase
        end
    end

    // Parser and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pst_q     <= P_IDLE;
            op_q      <= '0;
            tmo_q     <= '0;
            pattern_q <= DEFAULT_PATTERN;
            divisor_q <= DEFAULT_DIV;
            en_q      <= 1'b1;
            upd_q     <= 1'b0;
        end else begin
            pst_q     <= pst_d;
            op_q      <= op_d;
            tmo_q     <= tmo_d;
            pattern_q <= pattern_d;
            divisor_q <= divisor_d;
            en_q      <= en_d;
            upd_q     <= upd_d;
        end
    end

    assign pattern    = pattern_q;
    assign divisor    = divisor_q;
    assign blink_en   = en_q;
    assign cfg_update = upd_q;
    assign frame_err  = rx_ferr;

endmodule

// File: tb/tb_remote_blink_ctrl.sv
// Self-checking bench for remote_blink_ctrl: directed scenarios plus
// random command traffic against a byte-level protocol model.
`timescale 1ns/1ps
module tb_remote_blink_ctrl;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int TMO      = 200;
    // sync(2) + idle detect(1) + half bit + 9 bits to stop mid + byte_valid(1)
    localparam int LAT      = 2 + 1 + BIT / 2 + 9 * BIT + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_rx = 1'b1;
    logic [7:0] pattern;
    logic [7:0] divisor;
    logic       blink_en;
    logic       cfg_update;
    logic       frame_err;

    remote_blink_ctrl #(
        .CLK_FREQ        (CLK_FREQ),
        .BAUD            (BAUD),
        .DEFAULT_PATTERN (8'hFF),
        .DEFAULT_DIV     (8'd4),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .pattern    (pattern),
        .divisor    (divisor),
        .blink_en   (blink_en),
        .cfg_update (cfg_update),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int upd_cnt = 0;
    int fe_cnt = 0;
    int last_upd_cyc = -1;
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_update) begin
                upd_cnt++;
                last_upd_cyc = cyc;
            end
            if (frame_err) fe_cnt++;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [7:0] m_pat = 8'hFF;
    logic [7:0] m_div = 8'd4;
    logic       m_en = 1'b1;
    bit         m_pend = 0;
    logic [7:0] m_op = 8'h00;
    int         m_upd = 0;
    int         m_fe = 0;

    function automatic bit known_op(input logic [7:0] b);
        return b == 8'h50 || b == 8'h44 || b == 8'h45;
    endfunction

    task automatic m_byte(input logic [7:0] b);
        if (!m_pend) begin
            if (known_op(b)) begin
                m_op = b;
                m_pend = 1;
            end
        end else begin
            m_pend = 0;
            if (m_op == 8'h50) begin
                m_pat = b;
                m_upd++;
            end else if (m_op == 8'h44) begin
                if (b != 0) begin
                    m_div = b;
                    m_upd++;
                end
            end else begin
                m_en = b[0];
                m_upd++;
            end
        end
    endtask

    task automatic m_ferr();
        m_pend = 0;
        m_fe++;
    endtask

    task automatic m_reset();
        m_pat = 8'hFF;
        m_div = 8'd4;
        m_en = 1'b1;
        m_pend = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".pattern"}, {24'd0, pattern}, {24'd0, m_pat});
        chk({tag, ".divisor"}, {24'd0, divisor}, {24'd0, m_div});
        chk({tag, ".div_nz"}, {31'd0, divisor != 8'd0}, 32'd1);
        chk({tag, ".blink_en"}, {31'd0, blink_en}, {31'd0, m_en});
        chk({tag, ".upd_cnt"}, upd_cnt, m_upd);
        chk({tag, ".fe_cnt"}, fe_cnt, m_fe);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one 8N1 frame; called and returns on a falling clock edge.
    task automatic send(input logic [7:0] b, input logic stop_bit,
                        output int t0);
        t0 = cyc;
        uart_rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            idle(BIT);
        end
        uart_rx = stop_bit;
        idle(BIT);
        uart_rx = 1'b1;
    endtask

    task automatic send_ok(input logic [7:0] b);
        int t;
        send(b, 1'b1, t);
        m_byte(b);
    endtask

    initial begin
        int t;
        int gap;
        int kind;
        logic [7:0] op;
        logic [7:0] arg;

        idle(3);
        rst = 1'b0;
        check_regs("reset");
        idle(100);
        check_regs("reset_quiet");

        // Pattern write with back-to-back frames and latency check
        send_ok(8'h50);
        send(8'hA5, 1'b1, t);
        m_byte(8'hA5);
        idle(5);
        check_regs("pat_a5");
        chk("cfg_latency", last_upd_cyc, t + LAT);

        // Divisor zero rejected, then accepted nonzero value
        send_ok(8'h44);
        send_ok(8'h00);
        idle(5);
        check_regs("div_zero");
        send_ok(8'h44);
        send_ok(8'h10);
        idle(5);
        check_regs("div_10");

        // Argument timeout drops the opcode
        send_ok(8'h45);
        idle(250);
        m_pend = 0;
        send_ok(8'h00);
        idle(5);
        check_regs("timeout");

        // Enable via bit 0, and a same-value rewrite still pulses
        send_ok(8'h45);
        send_ok(8'hFE);
        send_ok(8'h45);
        send_ok(8'h01);
        send_ok(8'h45);
        send_ok(8'h01);
        idle(5);
        check_regs("enable");

        // Broken stop bit, then unknown opcode
        send(8'h50, 1'b0, t);
        m_ferr();
        idle(20);
        send_ok(8'h33);
        idle(5);
        check_regs("ferr_idle");

        // Frame error after an opcode discards it
        send_ok(8'h50);
        send(8'h11, 1'b0, t);
        m_ferr();
        idle(20);
        send_ok(8'h22);
        idle(5);
        check_regs("ferr_arg");

        // Short low glitch is a false start
        uart_rx = 1'b0;
        idle(3);
        uart_rx = 1'b1;
        idle(150);
        check_regs("glitch");

        // Reset in the middle of an argument byte
        send_ok(8'h50);
        uart_rx = 1'b0;
        idle(3 * BIT);
        rst = 1'b1;
        uart_rx = 1'b1;
        idle(3);
        rst = 1'b0;
        m_reset();
        check_regs("rst_mid");
        idle(20);
        send_ok(8'h50);
        send_ok(8'h0F);
        idle(5);
        check_regs("after_rst");

        // Random command traffic
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 3);
            arg = 8'($urandom);
            if (kind == 0) begin
                op = 8'h50;
            end else if (kind == 1) begin
                op = 8'h44;
                if ($urandom_range(0, 3) == 0) arg = 8'h00;
            end else if (kind == 2) begin
                op = 8'h45;
            end else begin
                op = 8'($urandom);
                while (known_op(op)) op = 8'($urandom);
            end
            send_ok(op);
            if (kind != 3) send_ok(arg);
            gap = $urandom_range(0, 50);
            idle(gap + 5);
            check_regs("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
